// File: rtl/axi_ddr_responder_pkg.sv
// Shared types and helpers for the on-chip AXI responder that stands in for the DDR port.
package axi_ddr_responder_pkg;

    localparam int BYTE_W          = 8;
    localparam int BEAT_W          = 32 * BYTE_W;
    localparam int BEAT_ADDR_SHIFT = 3;
    localparam int ID_W            = 4;
    localparam int LEN_W           = 4;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_BURST = 2'd1,
        R_DRAIN = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic            last;
        logic [ID_W-1:0] id;
    } rd_tag_t;

    // Bus addresses count DQ words; eight of them make one memory beat.
    function automatic logic [63:0] beat_index(input logic [63:0] addr);
        return addr >> BEAT_ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/axi_rsp_sdpram.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
module axi_rsp_sdpram
    import axi_ddr_responder_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 10
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [DATA_W/BYTE_W-1:0] wbe_i,
    input  logic                     re_i,
    input  logic [ADDR_W-1:0]        raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Non-blocking update means a same-cycle read of the written row sees the old data.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
        if (we_i) begin
            for (int b = 0; b < DATA_W / BYTE_W; b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

endmodule

// File: rtl/axi_ddr_responder.sv
// AXI slave that replaces the DDR controller port with one on-chip beat-wide memory.
module axi_ddr_responder
    import axi_ddr_responder_pkg::*;
#(
    parameter int MEM_ROW_WIDTH    = 15,
    parameter int MEM_COLUMN_WIDTH = 10,
    parameter int MEM_BANK_WIDTH   = 3,
    parameter int CTRL_ADDR_WIDTH  = MEM_ROW_WIDTH + MEM_BANK_WIDTH + MEM_COLUMN_WIDTH,
    parameter int MEM_DQ_WIDTH     = 32,
    parameter int MEM_DEPTH_LOG2   = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [CTRL_ADDR_WIDTH-1:0]   axi_awaddr_i,
    input  logic [ID_W-1:0]              axi_awid_i,
    input  logic [LEN_W-1:0]             axi_awlen_i,
    input  logic [2:0]                   axi_awsize_i,
    input  logic [1:0]                   axi_awburst_i,
    input  logic                         axi_awvalid_i,
    output logic                         axi_awready_o,
    input  logic [MEM_DQ_WIDTH*8-1:0]    axi_wdata_i,
    input  logic [MEM_DQ_WIDTH-1:0]      axi_wstrb_i,
    input  logic                         axi_wvalid_i,
    output logic                         axi_wready_o,
    output logic                         axi_wlast_o,
    output logic [ID_W-1:0]              axi_bid_o,
    output logic                         axi_bvalid_o,
    input  logic                         axi_bready_i,
    input  logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr_i,
    input  logic [ID_W-1:0]              axi_arid_i,
    input  logic [LEN_W-1:0]             axi_arlen_i,
    input  logic [2:0]                   axi_arsize_i,
    input  logic [1:0]                   axi_arburst_i,
    input  logic                         axi_arvalid_i,
    output logic                         axi_arready_o,
    output logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata_o,
    output logic                         axi_rvalid_o,
    input  logic                         axi_rready_i,
    output logic                         axi_rlast_o,
    output logic [ID_W-1:0]              axi_rid_o
);

    localparam int DATA_W = MEM_DQ_WIDTH * BYTE_W;
    localparam int IDX_W  = MEM_DEPTH_LOG2;

    logic unused_ok;
    assign unused_ok = ^{axi_awsize_i, axi_awburst_i, axi_arsize_i, axi_arburst_i};

    logic             active_q;
    wr_state_e        wr_state_q, wr_state_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [LEN_W-1:0] wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
    logic [ID_W-1:0]  wr_id_q, wr_id_d;
    logic             mem_we;

    rd_state_e        rd_state_q, rd_state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [LEN_W-1:0] rd_len_q, rd_len_d, rd_iss_q, rd_iss_d;
    logic [ID_W-1:0]  rd_id_q, rd_id_d;
    logic             rd_issue, inflight_q, inflight_last_q;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] fifo_data_q [2];
    rd_tag_t           fifo_tag_q  [2];
    logic              fifo_wr_ptr_q, fifo_rd_ptr_q, fifo_pop;
    logic [1:0]        fifo_cnt_q, occ_next;

    always_comb begin
        wr_state_d    = wr_state_q;
        wr_idx_d      = wr_idx_q;
        wr_len_d      = wr_len_q;
        wr_cnt_d      = wr_cnt_q;
        wr_id_d       = wr_id_q;
        mem_we        = 1'b0;
        axi_awready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_bvalid_o  = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                axi_awready_o = active_q;
                if (active_q && axi_awvalid_i) begin
                    wr_idx_d   = IDX_W'(beat_index(64'(axi_awaddr_i)));
                    wr_len_d   = axi_awlen_i;
                    wr_id_d    = axi_awid_i;
                    wr_cnt_d   = '0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                axi_wready_o = 1'b1;
                if (axi_wvalid_i) begin
                    mem_we   = 1'b1;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    wr_cnt_d = wr_cnt_q + LEN_W'(1);
                    if (wr_cnt_q == wr_len_q) begin
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                axi_bvalid_o = 1'b1;
                if (axi_bready_i) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign axi_wlast_o = axi_wready_o && (wr_cnt_q == wr_len_q);
    assign axi_bid_o   = wr_id_q;

    // Occupancy counts this cycle's pop so a held-high rready streams one beat per cycle.
    assign fifo_pop = (fifo_cnt_q != 2'd0) && axi_rready_i;
    assign occ_next = fifo_cnt_q - {1'b0, fifo_pop} + {1'b0, inflight_q};

    always_comb begin
        rd_state_d    = rd_state_q;
        rd_idx_d      = rd_idx_q;
        rd_len_d      = rd_len_q;
        rd_iss_d      = rd_iss_q;
        rd_id_d       = rd_id_q;
        rd_issue      = 1'b0;
        axi_arready_o = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                axi_arready_o = active_q;
                if (active_q && axi_arvalid_i) begin
                    rd_idx_d   = IDX_W'(beat_index(64'(axi_araddr_i)));
                    rd_len_d   = axi_arlen_i;
                    rd_id_d    = axi_arid_i;
                    rd_iss_d   = '0;
                    rd_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (occ_next < 2'd2) begin
                    rd_issue = 1'b1;
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                    rd_iss_d = rd_iss_q + LEN_W'(1);
                    if (rd_iss_q == rd_len_q) begin
                        rd_state_d = R_DRAIN;
                    end
                end
            end
            R_DRAIN: begin
                if (fifo_cnt_q == 2'd0 && !inflight_q) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign axi_rvalid_o = (fifo_cnt_q != 2'd0);
    assign axi_rdata_o  = fifo_data_q[fifo_rd_ptr_q];
    assign axi_rid_o    = fifo_tag_q[fifo_rd_ptr_q].id;
    assign axi_rlast_o  = axi_rvalid_o && fifo_tag_q[fifo_rd_ptr_q].last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q   <= 1'b0;
            wr_state_q <= W_IDLE;
            wr_idx_q   <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
            wr_id_q    <= '0;
            rd_state_q <= R_IDLE;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            rd_iss_q   <= '0;
            rd_id_q    <= '0;
        end else begin
            active_q   <= 1'b1;
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_len_q   <= wr_len_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_id_q    <= wr_id_d;
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_len_q   <= rd_len_d;
            rd_iss_q   <= rd_iss_d;
            rd_id_q    <= rd_id_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_wr_ptr_q   <= 1'b0;
            fifo_rd_ptr_q   <= 1'b0;
            fifo_cnt_q      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_tag_q[i]  <= '0;
            end
        end else begin
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && (rd_iss_q == rd_len_q);
            if (inflight_q) begin
                fifo_data_q[fifo_wr_ptr_q] <= ram_rdata;
                fifo_tag_q[fifo_wr_ptr_q]  <= '{last: inflight_last_q, id: rd_id_q};
                fifo_wr_ptr_q              <= ~fifo_wr_ptr_q;
            end
            if (fifo_pop) begin
                fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, fifo_pop};
        end
    end

    axi_rsp_sdpram #(
        .DATA_W (DATA_W),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (wr_idx_q),
        .wdata_i (axi_wdata_i),
        .wbe_i   (axi_wstrb_i),
        .re_i    (rd_issue),
        .raddr_i (rd_idx_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_axi_ddr_responder.sv
// Randomized bench: bursts checked against a flat byte-lane memory model.
module tb_axi_ddr_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [27:0]  awaddr, araddr;
    logic [3:0]   awid, awlen, arid, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [255:0] wdata, rdata;
    logic [31:0]  wstrb;
    logic [3:0]   bid, rid;
    logic         arvalid, arready, rvalid, rready, rlast;

    int total = 0;
    int bad   = 0;

    logic [255:0] ref_mem [1024];
    logic [255:0] wd [16];
    logic [31:0]  ws [16];

    always #5 clk = ~clk;

    axi_ddr_responder dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .axi_awaddr_i  (awaddr),
        .axi_awid_i    (awid),
        .axi_awlen_i   (awlen),
        .axi_awsize_i  (awsize),
        .axi_awburst_i (awburst),
        .axi_awvalid_i (awvalid),
        .axi_awready_o (awready),
        .axi_wdata_i   (wdata),
        .axi_wstrb_i   (wstrb),
        .axi_wvalid_i  (wvalid),
        .axi_wready_o  (wready),
        .axi_wlast_o   (wlast),
        .axi_bid_o     (bid),
        .axi_bvalid_o  (bvalid),
        .axi_bready_i  (bready),
        .axi_araddr_i  (araddr),
        .axi_arid_i    (arid),
        .axi_arlen_i   (arlen),
        .axi_arsize_i  (arsize),
        .axi_arburst_i (arburst),
        .axi_arvalid_i (arvalid),
        .axi_arready_o (arready),
        .axi_rdata_o   (rdata),
        .axi_rvalid_o  (rvalid),
        .axi_rready_i  (rready),
        .axi_rlast_o   (rlast),
        .axi_rid_o     (rid)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic do_write(input logic [27:0] addr, input logic [3:0] id, input int len, input int gap_pct);
        int  k, cyc, base;
        bit  done;
        base = int'(addr[12:3]);
        $display("wr addr=%h id=%0d len=%0d", addr, id, len);
        awaddr = addr; awid = id; awlen = 4'(len); awvalid = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!awready && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        if (!awready) begin
            check_eq("aw_timeout", 256'(awready), 256'(1));
            awvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        k = 0; cyc = 0;
        while (k <= len && cyc < 300) begin
            wvalid = ($urandom_range(0, 99) >= gap_pct);
            wdata  = wd[k];
            wstrb  = ws[k];
            @(negedge clk);
            if (wvalid && wready) begin
                check_eq("wlast", 256'(wlast), 256'(k == len));
                for (int b = 0; b < 32; b++)
                    if (ws[k][b]) ref_mem[(base + k) % 1024][b*8 +: 8] = wd[k][b*8 +: 8];
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        wvalid = 1'b0;
        if (k <= len) begin
            check_eq("w_timeout", 256'(k), 256'(len + 1));
            return;
        end
        cyc = 0; done = 1'b0;
        while (!done && cyc < 100) begin
            bready = ($urandom_range(0, 99) < 60);
            @(negedge clk);
            if (bvalid) begin
                check_eq("bid", 256'(bid), 256'(id));
                if (bready) done = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bready = 1'b0;
        if (!done) check_eq("b_timeout", 256'(done), 256'(1));
        @(negedge clk);
        check_eq("b_clear", 256'({bvalid, awready}), 256'(2'b01));
        @(posedge clk); #1;
    endtask

    // mode 0: rready high, 1: random rready, 2: repeating 1-0-0-1 pattern
    task automatic do_read(input logic [27:0] addr, input logic [3:0] id, input int len, input int mode);
        int k, cyc, edges, first_e, base;
        bit stalled;
        logic [255:0] held;
        base = int'(addr[12:3]);
        $display("rd addr=%h id=%0d len=%0d mode=%0d", addr, id, len, mode);
        araddr = addr; arid = id; arlen = 4'(len); arvalid = 1'b1; rready = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!arready && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        if (!arready) begin
            check_eq("ar_timeout", 256'(arready), 256'(1));
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        k = 0; edges = 0; first_e = -1; stalled = 1'b0; held = '0;
        while (k <= len && edges < 300) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = 1'($urandom_range(0, 1));
                default: rready = (edges % 4 == 0) || (edges % 4 == 3);
            endcase
            @(negedge clk);
            if (stalled) begin
                check_eq("rvalid_hold", 256'(rvalid), 256'(1));
                check_eq("rdata_hold", rdata, held);
            end
            stalled = 1'b0;
            if (rvalid) begin
                if (first_e < 0) begin
                    first_e = edges;
                    if (mode == 0) check_eq("r_latency", 256'(edges), 256'(2));
                end
                if (rready) begin
                    check_eq("rdata", rdata, ref_mem[(base + k) % 1024]);
                    check_eq("rlast", 256'(rlast), 256'(k == len));
                    check_eq("rid", 256'(rid), 256'(id));
                    k++;
                end else begin
                    stalled = 1'b1;
                    held = rdata;
                end
            end
            @(posedge clk); #1;
            edges++;
        end
        rready = 1'b0;
        if (k <= len) begin
            check_eq("r_timeout", 256'(k), 256'(len + 1));
            return;
        end
        if (mode == 0) check_eq("r_throughput", 256'(edges - 1 - first_e), 256'(len));
        @(negedge clk);
        check_eq("r_empty", 256'(rvalid), 256'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        awaddr = '0; awid = '0; awlen = '0; awsize = 3'd5; awburst = 2'd1; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arsize = 3'd5; arburst = 2'd1; arvalid = 1'b0;
        rready = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", 256'({awready, wready, wlast, bvalid, bid, arready, rvalid, rlast, rid}), 256'(0));
        check_eq("rst_rdata", rdata, 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_after_rst", 256'({awready, arready}), 256'(2'b11));
        @(posedge clk); #1;

        // Give the whole memory known contents so every read has a defined reference.
        for (int blk = 0; blk < 64; blk++) begin
            for (int k = 0; k < 16; k++) begin
                wd[k] = rand256();
                ws[k] = '1;
            end
            do_write(28'(blk * 16 * 8), 4'(blk), 15, 0);
        end

        for (int k = 0; k < 4; k++) begin
            wd[k] = 256'(k);
            ws[k] = '1;
        end
        do_write(28'h40, 4'h3, 3, 20);
        do_read(28'h40, 4'hA, 3, 0);

        wd[0] = '1; ws[0] = '1;
        do_write(28'(5 << 3), 4'h1, 0, 0);
        wd[0] = '0; ws[0] = 32'h0000_000F;
        do_write(28'(5 << 3), 4'h2, 0, 0);
        do_read(28'(5 << 3), 4'h4, 0, 0);

        do_read(28'h100, 4'h6, 15, 2);

        wd[0] = rand256(); wd[1] = rand256(); ws[0] = '1; ws[1] = '1;
        do_write(28'(1023 << 3), 4'h5, 1, 0);
        do_read(28'h0, 4'h6, 0, 0);
        do_read(28'(1023 << 3), 4'h7, 1, 0);
        do_read(28'h8001FF8, 4'h8, 1, 0);

        // Reset in the middle of an 8-beat write after two beats have been accepted.
        base = 200;
        awaddr = 28'(base << 3); awid = 4'h9; awlen = 4'd7; awvalid = 1'b1;
        @(negedge clk);
        check_eq("mid_awready", 256'(awready), 256'(1));
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wvalid = 1'b1; wdata = rand256(); wstrb = '1;
            @(negedge clk);
            check_eq("mid_wready", 256'(wready), 256'(1));
            if (wready) ref_mem[base + k] = wdata;
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_outs", 256'({awready, wready, bvalid}), 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq("no_bvalid", 256'(bvalid), 256'(0));
        end
        check_eq("mid_idle", 256'({awready, wready}), 256'(2'b10));
        @(posedge clk); #1;
        do_read(28'(base << 3), 4'hC, 1, 0);
        for (int k = 0; k < 8; k++) begin
            wd[k] = rand256();
            ws[k] = '1;
        end
        do_write(28'(base << 3), 4'hB, 7, 30);
        do_read(28'(base << 3), 4'hD, 7, 1);

        for (int it = 0; it < 25; it++) begin
            int len;
            logic [27:0] a;
            len = $urandom_range(0, 15);
            a = 28'($urandom);
            for (int k = 0; k < 16; k++) begin
                wd[k] = rand256();
                ws[k] = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            end
            do_write(a, 4'($urandom), len, $urandom_range(0, 50));
            if ($urandom_range(0, 1) == 1) a = a + 28'($urandom_range(0, 8) << 3);
            do_read(a, 4'($urandom), $urandom_range(0, 15), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
